reservation_station: RTL
========================

Name: reservation_station

Overview:
- Sits directly downstream of RegisterRenaming in the Tomasulo pipeline.
- Buffers renamed instructions (the PHYS_REG triple src1/src2/dest plus function code) until both source physical registers have been produced.
- Snoops the CDB for wakeup tags.
- Issues one ready instruction per cycle to a single functional unit, using a valid/ready handshake.

Parameters:
- RS_SIZE, 8: number of entries; power of two, 2..16.
- FUNC_LEN, 4: width of the opaque function/opcode field carried with each entry.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all entries.
- squash  input  1  synchronous flush; invalidates all entries at next posedge.
- dispatch_valid  input  1  rename stage presents an instruction this cycle (driven from assign_flag).
- dispatch_ready  output  1  at least one free entry; registered-occupancy based.
- dispatch_phys_reg  input  PHYS_REG  renamed src1/src2/dest tags, each REG_ADDR_LEN bits.
- dispatch_func  input  FUNC_LEN  function code.
- dispatch_src1_ready  input  1  src1 value already available at dispatch.
- dispatch_src2_ready  input  1  src2 value already available at dispatch.
- cdb_valid  input  1  a result broadcast is present.
- cdb_tag  input  REG_ADDR_LEN  physical register being broadcast.
- issue_valid  output  1  an entry is eligible to issue.
- issue_ready  input  1  functional unit accepts this cycle.
- issue_phys_reg  output  PHYS_REG  tags of the selected entry.
- issue_func  output  FUNC_LEN  function code of the selected entry.
- rs_count  output  $clog2(RS_SIZE)+1  number of valid entries.

Behaviour:
- Reset (async, active-high):
  - All entry valid bits cleared.
  - rs_count=0, dispatch_ready=1, issue_valid=0.
  - issue_phys_reg and issue_func = 0.
- Entry state: valid, phys_reg, func, rdy1, rdy2.
- Dispatch:
  - Accepted when dispatch_valid && dispatch_ready.
  - The lowest-index free entry is written at posedge.
  - Initial rdy bit = dispatch_srcN_ready OR (cdb_valid && cdb_tag==srcN), so a same-cycle broadcast is never lost.
  - When dispatch_valid && !dispatch_ready, nothing is written and the rename stage must hold the instruction.
- Wakeup:
  - Each posedge with cdb_valid, every valid entry whose src tag equals cdb_tag sets that rdy bit.
  - Both sources match if both tags are equal.
- Select (combinational):
  - An entry is eligible when valid && rdy1 && rdy2.
  - issue_valid = any eligible entry.
  - issue_* carry the lowest-index eligible entry.
  - When no entry is eligible, issue_* = 0.
- Issue:
  - On issue_valid && issue_ready, the selected entry is cleared at posedge.
  - If issue_ready is low, state holds and the outputs stay stable unless a lower-index entry becomes eligible.
- Latency:
  - Minimum dispatch-to-issue is 1 cycle: a ready-at-dispatch instruction is visible on issue_* the cycle after acceptance.
  - CDB wakeup-to-issue is 1 cycle (without the optional feature).
- Full:
  - dispatch_ready = (rs_count != RS_SIZE), computed from registered state.
  - A slot freed by issue in the same cycle is not reusable until the next cycle.
- Dispatch and issue in the same cycle:
  - Both happen.
  - rs_count is unchanged.
  - The freed and the written entries are different.
- rs_count update:
  - +1 on accepted dispatch.
  - -1 on issue.
  - Never wraps.
- Squash:
  - Overrides dispatch, issue and wakeup.
  - All entries become invalid at posedge; rs_count=0.
- Reset asserted mid-operation: immediate clear, independent of clk.

Optional Feature:
- Macro: RS_CDB_BYPASS_EN.
- Defined:
  - An entry whose only missing operand matches cdb_tag while cdb_valid is high is eligible in that same cycle.
  - Wakeup-to-issue latency becomes 0.
  - An entry issued this way is freed normally.
- Undefined:
  - Eligibility uses only the registered rdy bits.
  - Wakeup-to-issue latency is 1 cycle.

Decomposition:
- Shared header (alongside the existing rename types):
  - REG_ADDR_LEN and the PHYS_REG struct, reused unchanged.
  - New RS_ENTRY struct (valid, phys_reg, func, rdy1, rdy2).
  - RS_SIZE default constant.
- Sub-module rs_select:
  - Parameterised lowest-index priority encoder, returning found plus index.
  - Instantiated twice: free-slot search and eligible-entry search.

Test Plan:
1. After reset, dispatch {src1:1,src2:2,dest:3} with both ready bits high, issue_ready=1 -> next cycle issue_valid=1 and issue_phys_reg={1,2,3}; the cycle after, rs_count=0.
2. Dispatch {src1:4,src2:5,dest:6} with both ready bits low; cdb_tag=4 then cdb_tag=5 on consecutive cycles -> issue_valid stays 0 until the cycle after tag 5 (the same cycle under RS_CDB_BYPASS_EN).
3. Fill 8 unready entries with issue_ready=0 -> rs_count=8 and dispatch_ready=0. A 9th dispatch attempt is ignored: rs_count stays 8 and the contents are unchanged.
4. Dispatch with src1 tag 7 unready while cdb_valid=1, cdb_tag=7 in the same cycle -> entry captured with rdy1=1 and issues the next cycle.
5. Entries 0 and 2 eligible, issue_ready=0 for 3 cycles, then 1 -> entry 0 is held on issue_* for 3 cycles; after acceptance, entry 2 is presented.
6. 5 valid entries; assert squash together with dispatch_valid=1 -> next cycle rs_count=0 and issue_valid=0. Async reset pulsed between clock edges clears the block immediately.

Source files
------------

// File: rtl/reservation_station_pkg.sv
// rtl/reservation_station_pkg.sv - shared rename/reservation-station types and defaults
package reservation_station_pkg;

    localparam int REG_ADDR_LEN    = 6;
    localparam int RS_SIZE_DEFAULT = 8;
    localparam int RS_FUNC_LEN     = 4;

    typedef struct packed {
        logic [REG_ADDR_LEN-1:0] src1;
        logic [REG_ADDR_LEN-1:0] src2;
        logic [REG_ADDR_LEN-1:0] dest;
    } PHYS_REG;

    typedef struct packed {
        logic                   valid;
        PHYS_REG                phys_reg;
        logic [RS_FUNC_LEN-1:0] func;
        logic                   rdy1;
        logic                   rdy2;
    } RS_ENTRY;

    function automatic logic tag_hit(
        input logic                    bus_valid,
        input logic [REG_ADDR_LEN-1:0] bus_tag,
        input logic [REG_ADDR_LEN-1:0] src_tag
    );
        return bus_valid && (bus_tag == src_tag);
    endfunction

endpackage

// File: rtl/reservation_station_select.sv
// rtl/reservation_station_select.sv - lowest-index priority encoder (rs_select)
module rs_select #(
    parameter  int N = 8,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    output logic         found,
    output logic [W-1:0] idx
);

    // Scan downward so the last assignment wins with the lowest set index.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = W'(i);
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - Tomasulo reservation station; RS_CDB_BYPASS_EN enables same-cycle CDB wakeup issue
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int RS_SIZE  = RS_SIZE_DEFAULT,
    parameter int FUNC_LEN = RS_FUNC_LEN
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         squash,
    input  logic                         dispatch_valid,
    output logic                         dispatch_ready,
    input  PHYS_REG                      dispatch_phys_reg,
    input  logic [FUNC_LEN-1:0]          dispatch_func,
    input  logic                         dispatch_src1_ready,
    input  logic                         dispatch_src2_ready,
    input  logic                         cdb_valid,
    input  logic [REG_ADDR_LEN-1:0]      cdb_tag,
    output logic                         issue_valid,
    input  logic                         issue_ready,
    output PHYS_REG                      issue_phys_reg,
    output logic [FUNC_LEN-1:0]          issue_func,
    output logic [$clog2(RS_SIZE):0]     rs_count
);

    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int CNT_W = IDX_W + 1;

    RS_ENTRY            rs_q [RS_SIZE];
    logic [CNT_W-1:0]   count_q;
    logic [RS_SIZE-1:0] free_vec;
    logic [RS_SIZE-1:0] elig_vec;
    logic               free_found;
    logic               elig_found;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   elig_idx;
    logic               do_disp;
    logic               do_issue;

    always_comb begin
        free_vec = '0;
        elig_vec = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            free_vec[i] = !rs_q[i].valid;
`ifdef RS_CDB_BYPASS_EN
            elig_vec[i] = rs_q[i].valid
                && (rs_q[i].rdy1 || tag_hit(cdb_valid, cdb_tag, rs_q[i].phys_reg.src1))
                && (rs_q[i].rdy2 || tag_hit(cdb_valid, cdb_tag, rs_q[i].phys_reg.src2));
`else
            elig_vec[i] = rs_q[i].valid && rs_q[i].rdy1 && rs_q[i].rdy2;
`endif
        end
    end

    rs_select #(.N(RS_SIZE)) u_free_sel (
        .req   (free_vec),
        .found (free_found),
        .idx   (free_idx)
    );

    rs_select #(.N(RS_SIZE)) u_issue_sel (
        .req   (elig_vec),
        .found (elig_found),
        .idx   (elig_idx)
    );

    // Occupancy is registered, so a slot freed by issue this cycle is only reusable next cycle.
    assign dispatch_ready = (count_q != CNT_W'(RS_SIZE));
    assign do_disp        = dispatch_valid && dispatch_ready && free_found;
    assign issue_valid    = elig_found;
    assign do_issue       = issue_valid && issue_ready;
    assign rs_count       = count_q;

    always_comb begin
        issue_phys_reg = '0;
        issue_func     = '0;
        if (elig_found) begin
            issue_phys_reg = rs_q[elig_idx].phys_reg;
            issue_func     = FUNC_LEN'(rs_q[elig_idx].func);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                rs_q[i] <= '0;
            end
            count_q <= '0;
        end else if (squash) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                rs_q[i].valid <= 1'b0;
            end
            count_q <= '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (rs_q[i].valid && tag_hit(cdb_valid, cdb_tag, rs_q[i].phys_reg.src1)) begin
                    rs_q[i].rdy1 <= 1'b1;
                end
                if (rs_q[i].valid && tag_hit(cdb_valid, cdb_tag, rs_q[i].phys_reg.src2)) begin
                    rs_q[i].rdy2 <= 1'b1;
                end
            end
            if (do_issue) begin
                rs_q[elig_idx].valid <= 1'b0;
            end
            // free_idx always points at an invalid entry, so it never collides with the issued one.
            if (do_disp) begin
                rs_q[free_idx].valid    <= 1'b1;
                rs_q[free_idx].phys_reg <= dispatch_phys_reg;
                rs_q[free_idx].func     <= RS_FUNC_LEN'(dispatch_func);
                rs_q[free_idx].rdy1     <= dispatch_src1_ready
                                           || tag_hit(cdb_valid, cdb_tag, dispatch_phys_reg.src1);
                rs_q[free_idx].rdy2     <= dispatch_src2_ready
                                           || tag_hit(cdb_valid, cdb_tag, dispatch_phys_reg.src2);
            end
            case ({do_disp, do_issue})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
